// File: rtl/o_serdes_tx_pkg.sv
// Shared definitions for the output serializer: FSM encoding and WIDTH bounds.
package o_serdes_tx_pkg;

  // Shifter state: IDLE means the shifter is empty, SHIFT means a word is on Q.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int WIDTH_MIN = 3;
  localparam int WIDTH_MAX = 10;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/o_serdes_tx_hold.sv
// One-entry holding register sitting in front of the shifter.
//
// Handshake: a word (data + oe) is accepted on a rising edge where
// in_valid && in_ready; in_ready is simply "not full" and never depends on
// in_valid. The shifter drains the entry by asserting pop for one cycle.
// Reset wins over both accept and pop.
module o_serdes_tx_hold
  import o_serdes_tx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_oe,
  input  logic             pop,
  output logic             full,
  output logic [WIDTH-1:0] out_data,
  output logic             out_oe
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             oe_q, oe_d;

  assign in_ready = ~full_q;
  assign full     = full_q;
  assign out_data = data_q;
  assign out_oe   = oe_q;

  // Next holding contents: drain on pop, then load on accept (accept wins).
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    oe_d   = oe_q;
    if (pop) begin
      full_d = 1'b0;
    end
    if (in_valid && in_ready) begin
      full_d = 1'b1;
      data_d = in_data;
      oe_d   = in_oe;
    end
  end

  // Holding register; reset suppresses any accept on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
      oe_q   <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      oe_q   <= oe_d;
    end
  end

endmodule

// File: rtl/o_serdes_tx.sv
// Parallel-to-serial transmitter driving a downstream tri-state output buffer.
// Bit 0 of each word goes out first; back-to-back words are sent gap-free and
// an UNDERRUN pulse marks the cycle after a word ends with nothing queued.
module o_serdes_tx
  import o_serdes_tx_pkg::*;
#(
  parameter int   WIDTH    = 4,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             DATA_VALID,
  input  logic             OE_IN,
  output logic             DATA_READY,
  output logic             Q,
  output logic             OE_OUT,
  output logic             UNDERRUN,
  output state_e           dbg_state
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  // Out-of-range WIDTH is rejected while the design is elaborated.
  if (!width_ok(WIDTH)) begin : g_width_check
    $error("o_serdes_tx: WIDTH=%0d outside legal range %0d..%0d",
           WIDTH, WIDTH_MIN, WIDTH_MAX);
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             oe_q, oe_d;
  logic             underrun_q, underrun_d;

  logic             pop;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             hold_oe;

  o_serdes_tx_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk      (CLK),
    .rst_n    (RST),
    .in_valid (DATA_VALID),
    .in_ready (DATA_READY),
    .in_data  (D),
    .in_oe    (OE_IN),
    .pop      (pop),
    .full     (hold_full),
    .out_data (hold_data),
    .out_oe   (hold_oe)
  );

  // Next-state logic: load from holding when empty or at the last bit,
  // otherwise shift right and count; flag underrun when nothing follows.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    oe_d       = oe_q;
    underrun_d = 1'b0;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hold_full) begin
          state_d = ST_SHIFT;
          sh_d    = hold_data;
          oe_d    = hold_oe;
          cnt_d   = '0;
          pop     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (hold_full) begin
            sh_d = hold_data;
            oe_d = hold_oe;
            pop  = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            oe_d       = 1'b0;
            underrun_d = 1'b1;
          end
        end else begin
          sh_d  = sh_q >> 1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        oe_d    = 1'b0;
      end
    endcase
  end

  // State, shifter and pulse registers; reset drops any word in flight.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      sh_q       <= '0;
      cnt_q      <= '0;
      oe_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      oe_q       <= oe_d;
      underrun_q <= underrun_d;
    end
  end

  // Serial outputs: shifter LSB while shifting, idle level otherwise.
  always_comb begin
    Q         = (state_q == ST_SHIFT) ? sh_q[0] : IDLE_VAL;
    OE_OUT    = (state_q == ST_SHIFT) && oe_q;
    UNDERRUN  = underrun_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_o_serdes_tx.sv
// Bench for o_serdes_tx: directed word sequences with hand-built expected
// output tables, plus a random phase checked against a bit-queue model and a
// tri-state differential buffer model.
module tb_o_serdes_tx;
  import o_serdes_tx_pkg::*;

  localparam int   W        = 4;
  localparam logic IDLE_VAL = 1'b0;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         RST;
  logic [W-1:0] D;
  logic         DATA_VALID;
  logic         OE_IN;
  logic         DATA_READY;
  logic         Q;
  logic         OE_OUT;
  logic         UNDERRUN;
  state_e       dbg_state;

  o_serdes_tx #(
    .WIDTH    (W),
    .IDLE_VAL (IDLE_VAL)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .D          (D),
    .DATA_VALID (DATA_VALID),
    .OE_IN      (OE_IN),
    .DATA_READY (DATA_READY),
    .Q          (Q),
    .OE_OUT     (OE_OUT),
    .UNDERRUN   (UNDERRUN),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {DATA_READY, UNDERRUN, OE_OUT, Q} observed after one edge.
  logic [3:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  logic [3:0] mon_e;
  logic [3:0] mon_act;

  function automatic logic buf_p(input logic oe, input logic d);
    return oe ? d : 1'bz;
  endfunction

  function automatic logic buf_n(input logic oe, input logic d);
    return oe ? ~d : 1'bz;
  endfunction

  // Monitor: one expected entry per cycle, sampled on the falling edge.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = {DATA_READY, UNDERRUN, OE_OUT, Q};
      n_cmp++;
      if (mon_act !== mon_e) begin
        n_fail++;
        $display("FAIL out_tuple t=%0t {rdy,ur,oe,q} got=%b want=%b",
                 $time, mon_act, mon_e);
      end
      n_cmp++;
      if ((buf_p(OE_OUT, Q) !== buf_p(mon_e[1], mon_e[0])) ||
          (buf_n(OE_OUT, Q) !== buf_n(mon_e[1], mon_e[0]))) begin
        n_fail++;
        $display("FAIL diff_buf t=%0t p/n got=%b%b want=%b%b", $time,
                 buf_p(OE_OUT, Q), buf_n(OE_OUT, Q),
                 buf_p(mon_e[1], mon_e[0]), buf_n(mon_e[1], mon_e[0]));
      end
    end
  end

  // ---------------- reference model (random phase) ----------------
  // Holds a queue of pending serial bits {oe, d}; the front is what Q shows.
  bit           rand_phase = 1'b0;
  logic [1:0]   m_bq[$];
  bit           m_full = 1'b0;
  logic [W-1:0] m_d;
  logic         m_oe;

  always @(posedge CLK) begin
    logic ur;
    logic full_pre;
    ur       = 1'b0;
    full_pre = m_full;
    if (!RST) begin
      m_bq.delete();
      m_full = 1'b0;
    end else begin
      if (m_bq.size() > 0) begin
        void'(m_bq.pop_front());
        if (m_bq.size() == 0 && !full_pre) ur = 1'b1;
      end
      if (m_bq.size() == 0 && full_pre) begin
        for (int i = 0; i < W; i++) m_bq.push_back({m_oe, m_d[i]});
        m_full = 1'b0;
      end
      if (DATA_VALID && !full_pre) begin
        m_full = 1'b1;
        m_d    = D;
        m_oe   = OE_IN;
      end
    end
    if (rand_phase) begin
      if (m_bq.size() > 0)
        exp_q.push_back({~m_full, ur, m_bq[0][1], m_bq[0][0]});
      else
        exp_q.push_back({~m_full, ur, 1'b0, IDLE_VAL});
    end
  end

  // ---------------- directed expectation tables ----------------
  localparam logic [3:0] T0 [4]  = '{4'b1000, 4'b1000, 4'b1000, 4'b1000};
  localparam logic [3:0] T1 [8]  = '{4'b0000, 4'b1011, 4'b1011, 4'b1010,
                                     4'b1011, 4'b1100, 4'b1000, 4'b1000};
  localparam logic [3:0] T2 [11] = '{4'b0000, 4'b1010, 4'b0011, 4'b0010,
                                     4'b0011, 4'b1001, 4'b1000, 4'b1001,
                                     4'b1000, 4'b1100, 4'b1000};
  localparam logic [3:0] T3 [15] = '{4'b0000, 4'b1011, 4'b0011, 4'b0010,
                                     4'b0010, 4'b1000, 4'b0000, 4'b0001,
                                     4'b0001, 4'b1011, 4'b1010, 4'b1010,
                                     4'b1011, 4'b1100, 4'b1000};
  localparam logic [3:0] T4 [9]  = '{4'b0000, 4'b1011, 4'b0011, 4'b0011,
                                     4'b1000, 4'b1000, 4'b1000, 4'b1000,
                                     4'b1000};

  // ---------------- driver tasks ----------------
  // Offer a word and return 1ns after the edge that accepted it.
  task automatic send(input logic [W-1:0] d, input logic oe);
    int n;
    n          = 0;
    DATA_VALID = 1'b1;
    D          = d;
    OE_IN      = oe;
    while (!DATA_READY && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (!DATA_READY) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout got=ready0 want=ready1 word=%h", d);
    end
    @(posedge CLK);
    #1;
  endtask

  // Wait until the monitor has consumed every expected entry.
  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge CLK);
    @(negedge CLK);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_%s got=%0d left want=0 left", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge CLK);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST        = 1'b0;
    DATA_VALID = 1'b1;
    D          = 4'hF;
    OE_IN      = 1'b1;

    // Reset for two edges with a word offered: nothing may be accepted.
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) exp_q.push_back(T0[i]);
    RST        = 1'b1;
    DATA_VALID = 1'b0;
    wait_drain("reset_idle");
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state got=%0d want=%0d", dbg_state, ST_IDLE);
    end

    // Single word 1011 with drive enabled.
    send(4'b1011, 1'b1);
    for (int i = 0; i < 8; i++) exp_q.push_back(T1[i]);
    DATA_VALID = 1'b0;
    wait_drain("single");

    // Back-to-back A (drive) then 5 (high-Z).
    send(4'hA, 1'b1);
    for (int i = 0; i < 11; i++) exp_q.push_back(T2[i]);
    send(4'h5, 1'b0);
    DATA_VALID = 1'b0;
    wait_drain("b2b");

    // Backpressure with three words and DATA_VALID held.
    send(4'h3, 1'b1);
    for (int i = 0; i < 15; i++) exp_q.push_back(T3[i]);
    send(4'hC, 1'b0);
    send(4'h9, 1'b1);
    DATA_VALID = 1'b0;
    wait_drain("backpressure");

    // Reset while bit 2 of F is on Q with word 6 queued behind it.
    send(4'hF, 1'b1);
    for (int i = 0; i < 9; i++) exp_q.push_back(T4[i]);
    send(4'h6, 1'b1);
    DATA_VALID = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    wait_drain("mid_reset");

    // Random traffic checked against the model and buffer model.
    RST        = 1'b0;
    rand_phase = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b1;
    for (int c = 0; c < 500; c++) begin
      DATA_VALID = ($urandom_range(0, 3) != 0);
      D          = W'($urandom_range(0, 15));
      OE_IN      = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
    end
    DATA_VALID = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge CLK); #1;
    end
    rand_phase = 1'b0;
    wait_drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
